// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive sequencer: state encoding, defaults, line level.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned DefDataBits = 8;
    localparam logic        LineIdle    = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_sync_edge.sv
// Serial-line synchroniser with falling-edge detect; all stages start at the idle level.
module uart_rx_ctrl_sync_edge
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{LineIdle}};
            prev_q <= LineIdle;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    // Needs a seen-high sample, so a line held low never re-arms the start detector.
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: detects the start bit, gates the baud generator and samples one frame.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DefDataBits,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 8191
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic                 bps_hf_i,
    output logic                 bps_start_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 rx_busy_o
);

    localparam int unsigned CntW  = $clog2(DATA_BITS + 1);
    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  LastBit = CntW'(DATA_BITS - 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT);

    logic rx_s;
    logic fall;

    uart_rx_ctrl_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .rx_i  (rx_i),
        .rx_s_o(rx_s),
        .fall_o(fall)
    );

    rx_state_e            state_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic [WdogW-1:0]     wdog_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 bps_start_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 rx_busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            wdog_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            bps_start_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != StIdle) begin
                wdog_q <= bps_hf_i ? '0 : wdog_q + WdogW'(1);
            end
            // Lost baud pulses: abandon the frame rather than wait forever.
            if (state_q != StIdle && !bps_hf_i && wdog_q == WdogMax) begin
                frame_err_q <= 1'b1;
                state_q     <= StIdle;
                bps_start_q <= 1'b0;
                rx_busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (fall) begin
                            state_q     <= StStart;
                            bps_start_q <= 1'b1;
                            rx_busy_q   <= 1'b1;
                            wdog_q      <= '0;
                        end
                    end
                    StStart: begin
                        if (bps_hf_i) begin
                            if (!rx_s) begin
                                state_q   <= StData;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q     <= StIdle;
                                bps_start_q <= 1'b0;
                                rx_busy_q   <= 1'b0;
                            end
                        end
                    end
                    StData: begin
                        if (bps_hf_i) begin
                            shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                            if (bit_cnt_q == LastBit) begin
                                state_q <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        if (bps_hf_i) begin
                            if (rx_s) begin
                                rx_data_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q     <= StIdle;
                            bps_start_q <= 1'b0;
                            rx_busy_q   <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bps_start_o = bps_start_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign rx_busy_o   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a simple baud-generator model producing mid-bit pulses.
module tb_uart_rx_ctrl;

    localparam int BIT = 32;
    localparam int TO  = 100;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rx      = 1'b1;
    logic       bps_hf  = 1'b0;
    logic       hf_kill = 1'b0;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx_ctrl #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx),
        .bps_hf_i   (bps_hf),
        .bps_start_o(bps_start),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .rx_busy_o  (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud generator model: one registered pulse per bit period, at mid-bit.
    int gen_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_cnt <= 0;
            bps_hf  <= 1'b0;
        end else begin
            bps_hf <= 1'b0;
            if (!bps_start) begin
                gen_cnt <= 0;
            end else begin
                gen_cnt <= (gen_cnt == BIT - 1) ? 0 : gen_cnt + 1;
                if (gen_cnt == BIT / 2 - 1 && !hf_kill) bps_hf <= 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [7:0] last_data = 8'h00;
    int valid_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always_ff @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid || frame_err) check("excl", {31'd0, rx_valid & frame_err}, 0);
        if (rx_valid) begin
            n_valid++;
            last_data = rx_data;
            valid_cyc.push_back(cyc);
        end
        if (frame_err) n_err++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int err_at;
        logic [7:0] d6;

        // Reset state
        idle(3);
        check("rst_bps_start", bps_start, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        rst = 1'b1;
        idle(5);

        // 1: clean 0x55
        send_bit(1'b0);
        check("t1_bps_start_mid", bps_start, 1);
        check("t1_busy_mid", rx_busy, 1);
        for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        send_bit(1'b1);
        idle(2);
        check("t1_valid_cnt", n_valid, 1);
        check("t1_data", last_data, 8'h55);
        check("t1_err_cnt", n_err, 0);
        check("t1_bps_start_end", bps_start, 0);
        check("t1_busy_end", rx_busy, 0);

        // 4: 0x81 with bad stop bit, then line held low
        send_byte(8'h81, 1'b0);
        idle(2);
        check("t4_err_cnt", n_err, 1);
        check("t4_valid_cnt", n_valid, 1);
        check("t4_data_kept", rx_data, 8'h55);
        idle(3 * BIT);
        check("t4_low_busy", rx_busy, 0);
        check("t4_low_bps_start", bps_start, 0);
        check("t4_low_err_cnt", n_err, 1);
        rx = 1'b1;
        idle(2 * BIT);

        // 3: short glitch is a false start
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(BIT / 4);
        check("t3_busy_start", rx_busy, 1);
        idle(2 * BIT);
        check("t3_valid_cnt", n_valid, 1);
        check("t3_err_cnt", n_err, 1);
        check("t3_bps_start", bps_start, 0);
        check("t3_busy", rx_busy, 0);

        // 2: back-to-back 0xA3, 0x0F
        valid_cyc.delete();
        send_byte(8'hA3, 1'b1);
        check("t2_data_a3", last_data, 8'hA3);
        send_byte(8'h0F, 1'b1);
        idle(2);
        check("t2_valid_cnt", n_valid, 3);
        check("t2_data_0f", last_data, 8'h0F);
        check("t2_pulses", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2)
            check("t2_spacing", {31'd0, (valid_cyc[1] - valid_cyc[0] >= 10 * BIT - 2) &&
                                        (valid_cyc[1] - valid_cyc[0] <= 10 * BIT + 2)}, 1);

        // 5: baud pulses suppressed -> watchdog timeout
        hf_kill = 1'b1;
        rx = 1'b0;
        err_at = -1;
        for (int i = 1; i <= TO + 20; i++) begin
            @(negedge clk);
            if (frame_err) begin
                err_at = i;
                break;
            end
        end
        check("t5_timeout_window", {31'd0, (err_at >= TO) && (err_at <= TO + 8)}, 1);
        idle(1);
        check("t5_busy", rx_busy, 0);
        check("t5_bps_start", bps_start, 0);
        rx = 1'b1;
        hf_kill = 1'b0;
        idle(2 * BIT);
        check("t5_valid_cnt", n_valid, 3);

        // 6: reset during data bit 4 of 0xC6, then clean 0x3C
        d6 = 8'hC6;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d6[i]);
        rx = d6[4];
        idle(BIT / 2);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", rx_busy, 0);
        check("t6_rst_bps_start", bps_start, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_err", frame_err, 0);
        rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(2 * BIT);
        send_byte(8'h3C, 1'b1);
        idle(2);
        check("t6_data", rx_data, 8'h3C);
        check("t6_valid_cnt", n_valid, 4);
        check("t6_err_cnt", n_err, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
